// File: rtl/operation_fsm.sv
// Irrigation operation controller: drives pump/refill valve from field sensors, alarms on refill timeout.
// Moore FSM, outputs registered alongside the state (one cycle input-to-output latency, no backpressure).
module operation_fsm #(
    parameter int REFILL_TIMEOUT = 8
) (
    input  logic Ck,
    input  logic Clr,
    input  logic H1,
    input  logic O6,
    input  logic I5,
    input  logic I6,
    input  logic I7,
    output logic O7,
    output logic O8,
    output logic O9
);

    localparam int CW = (REFILL_TIMEOUT > 2) ? $clog2(REFILL_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFILL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MONITOR  = 3'd1,
        IRRIGATE = 3'd2,
        REFILL   = 3'd3,
        FAULT    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            o7_q, o8_q, o9_q;

    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!H1 || O6) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = MONITOR;
                MONITOR: begin
                    if (!I7)            state_d = REFILL;
                    else if (I6 && !I5) state_d = IRRIGATE;
                    else                state_d = MONITOR;
                end
                IRRIGATE: begin
                    if (!I7)           state_d = REFILL;
                    else if (!I6 || I5) state_d = MONITOR;
                    else               state_d = IRRIGATE;
                end
                REFILL: begin
                    // Water arriving on the terminal count still rescues the refill.
                    if (I7) begin
                        state_d = MONITOR;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = FAULT;
                    end else begin
                        state_d = REFILL;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                FAULT:    state_d = FAULT;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they always equal the decode of state_q.
    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o7_q    <= 1'b0;
            o8_q    <= 1'b0;
            o9_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o7_q    <= (state_d == IRRIGATE);
            o8_q    <= (state_d == REFILL);
            o9_q    <= (state_d == FAULT);
        end
    end

    assign O7 = o7_q;
    assign O8 = o8_q;
    assign O9 = o9_q;

endmodule

// File: tb/tb_operation_fsm.sv
// Directed bench for operation_fsm; outputs checked as {O7,O8,O9} one time unit after each rising edge.
module tb_operation_fsm;

    logic Ck = 1'b0;
    logic Clr, H1, O6, I5, I6, I7;
    logic O7, O8, O9;
    int   checks = 0;
    int   errors = 0;

    operation_fsm #(.REFILL_TIMEOUT(8)) dut (
        .Ck (Ck),
        .Clr(Clr),
        .H1 (H1),
        .O6 (O6),
        .I5 (I5),
        .I6 (I6),
        .I7 (I7),
        .O7 (O7),
        .O8 (O8),
        .O9 (O9)
    );

    always #5 Ck = ~Ck;

    task automatic chk(input string tag, input logic [2:0] exp);
        checks++;
        assert ({O7, O8, O9} === exp)
        else begin
            errors++;
            $error("FAIL %s: observed O7O8O9=%b expected %b", tag, {O7, O8, O9}, exp);
        end
    endtask

    task automatic tick();
        @(posedge Ck);
        #1;
    endtask

    task automatic run(input string tag, input int n, input logic [2:0] exp);
        for (int k = 0; k < n; k++) begin
            tick();
            chk(tag, exp);
        end
    endtask

    initial begin
        Clr = 1'b1; H1 = 1'b1; O6 = 1'b0; I5 = 1'b0; I6 = 1'b1; I7 = 1'b1;
        #2 Clr = 1'b0;
        #1 chk("reset_async", 3'b000);
        run("reset_hold", 3, 3'b000);

        Clr = 1'b1;
        run("reset_release_monitor", 1, 3'b000);

        O6 = 1'b1;
        run("init_busy", 5, 3'b000);
        O6 = 1'b0;
        run("init_done_monitor", 1, 3'b000);
        run("init_done_irrigate", 1, 3'b100);
        O6 = 1'b1;
        run("init_reassert", 1, 3'b000);
        O6 = 1'b0;
        run("resume_monitor", 1, 3'b000);
        run("resume_irrigate", 1, 3'b100);

        I5 = 1'b1;
        run("rain_stops_pump", 1, 3'b000);
        I5 = 1'b0;
        run("rain_clear_pump", 1, 3'b100);
        I6 = 1'b0;
        run("soil_wet_stops", 1, 3'b000);
        I6 = 1'b1;
        run("soil_dry_pump", 1, 3'b100);

        I7 = 1'b0;
        run("refill_3", 3, 3'b010);
        I7 = 1'b1;
        run("refill_done_monitor", 1, 3'b000);
        run("refill_done_irrigate", 1, 3'b100);

        I7 = 1'b0;
        run("dip_refill", 1, 3'b010);
        I7 = 1'b1;
        run("dip_monitor", 1, 3'b000);
        run("dip_irrigate", 1, 3'b100);

        I6 = 1'b0;
        run("to_monitor", 1, 3'b000);
        I7 = 1'b0;
        run("timeout_refill", 8, 3'b010);
        run("timeout_fault", 1, 3'b001);
        I7 = 1'b1;
        run("fault_sticky", 2, 3'b001);
        H1 = 1'b0;
        run("fault_window_close", 1, 3'b000);
        H1 = 1'b1;
        run("reopen_monitor", 1, 3'b000);

        I7 = 1'b0; I6 = 1'b1;
        run("prio_refill_over_irrigate", 1, 3'b010);
        I7 = 1'b1;
        run("prio_back_monitor", 1, 3'b000);
        run("prio_back_irrigate", 1, 3'b100);
        H1 = 1'b0; I7 = 1'b0;
        run("prio_window_wins", 1, 3'b000);

        H1 = 1'b1; I6 = 1'b0; I7 = 1'b1;
        run("tc_monitor", 1, 3'b000);
        I7 = 1'b0;
        run("tc_refill", 8, 3'b010);
        I7 = 1'b1;
        run("tc_rescue_monitor", 1, 3'b000);

        I6 = 1'b1;
        run("async_irrigate", 1, 3'b100);
        #2 Clr = 1'b0;
        #1 chk("async_clear_irrigate", 3'b000);
        Clr = 1'b1;
        I6 = 1'b0;
        run("re_monitor", 1, 3'b000);
        I7 = 1'b0;
        run("re_refill", 8, 3'b010);
        run("re_fault", 1, 3'b001);
        #2 Clr = 1'b0;
        #1 chk("async_clear_fault", 3'b000);
        run("fault_not_retained", 1, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operation_fsm.md
# operation_fsm

Irrigation operation controller for the agriculture control system. It runs after the initialization FSM has finished and while the operation window (H1) is open. It drives the irrigation pump (O7) and the reservoir refill valve (O8) from three field sensors (I5 rain, I6 soil dry, I7 water available). It raises a fault alarm (O9) when a reservoir refill does not complete in time.

## Interface

Parameters:
- REFILL_TIMEOUT, default 8: maximum number of consecutive cycles allowed in REFILL before FAULT. Legal range ≥ 2.

Ports:
- Ck, input, 1: system clock, rising-edge active.
- Clr, input, 1: reset, asynchronous, active-low. Clr=0 forces IDLE and clears all outputs and the counter immediately.
- H1, input, 1: operation window enable. 1 = operation allowed.
- O6, input, 1: initialization-busy flag from the init FSM. 1 = init in progress, so operation is blocked.
- I5, input, 1: rain sensor. 1 = raining, which inhibits irrigation.
- I6, input, 1: soil moisture sensor. 1 = soil dry, irrigation requested.
- I7, input, 1: reservoir level. 1 = water available, 0 = low.
- O7, output, 1: pump on.
- O8, output, 1: refill valve open.
- O9, output, 1: refill-timeout fault alarm.

## Operation

- Moore FSM with states IDLE, MONITOR, IRRIGATE, REFILL, FAULT. Use a 3-bit encoding.
- Outputs are decoded from the state register only:
  - IDLE and MONITOR: O7=0, O8=0, O9=0.
  - IRRIGATE: O7=1, O8=0, O9=0.
  - REFILL: O7=0, O8=1, O9=0.
  - FAULT: O7=0, O8=0, O9=1.
- Exactly one or none of O7/O8/O9 is high at any time.
- Global rule, highest priority, evaluated from any state: if H1=0 or O6=1, next state is IDLE.
- Otherwise, transitions per state:
  - IDLE: go to MONITOR.
  - MONITOR: if I7=0, go to REFILL. Else if I6=1 and I5=0, go to IRRIGATE. Else stay.
  - IRRIGATE: if I7=0, go to REFILL. Else if I6=0 or I5=1, go to MONITOR. Else stay.
  - REFILL: if I7=1, go to MONITOR. Else if refill counter = REFILL_TIMEOUT−1, go to FAULT. Else stay.
  - FAULT: stay. Exit only through the global rule or reset.
- Refill counter:
  - Cleared in every state other than REFILL, and on reset.
  - Increments by 1 each cycle the FSM is in REFILL and stays there.
  - Width is ceil(log2(REFILL_TIMEOUT)) bits, minimum 1. It never wraps, because FAULT is taken at the terminal count.
- Pump and refill are never on together. Sensor I7=0 always takes precedence over an irrigation request.
- Undefined state encodings recover to IDLE on the next edge.

## Timing

- Reset: while Clr=0, state is IDLE, O7=O8=O9=0 and the counter is 0, regardless of Ck and the other inputs. After Clr deasserts, the first rising edge evaluates IDLE transitions normally.
- All inputs are sampled on the rising edge of Ck. They are assumed synchronous to Ck; no synchronizers are in this block.
- Latency: an input change seen at edge n changes the outputs after edge n, i.e. one cycle of registered latency. There is no combinational input-to-output path.
- From enable to pump: H1=1 and O6=0 at edge n gives MONITOR. With I7=1, I6=1, I5=0 at edge n+1, IRRIGATE and O7=1 follow. Minimum is 2 edges.
- A single-cycle I7 dip during IRRIGATE gives REFILL for 1 cycle (O8 pulse), then MONITOR, then IRRIGATE again if the request persists. O7 is low for 2 cycles.
- Timeout: entering REFILL at edge n with I7 held 0 gives FAULT at edge n+REFILL_TIMEOUT. O8 is high for exactly REFILL_TIMEOUT cycles.
- Simultaneous events: when H1 falls together with any sensor change, IDLE wins. When I7=0 and I6=1 arrive together, REFILL wins. If I7 rises at the terminal count, MONITOR wins over FAULT.
- Asserting Clr mid-operation, including in FAULT, clears the outputs immediately. No state is retained.

## Test plan

- Reset: Clr=0 with H1=1, O6=0, I7=1, I6=1 → O7=O8=O9=0 throughout. Release Clr; one edge later the state is MONITOR and the outputs stay 000.
- Init gating: H1=1, O6=1 for 5 edges → outputs stay 000. Then O6=0, I7=1, I6=1, I5=0 → O7=1 on the 2nd edge. Then O6=1 → O7=0 on the next edge.
- Rain and moisture: in IRRIGATE, set I5=1 → O7=0 next edge. Set I5=0 → O7=1 next edge. Set I6=0 → O7=0 next edge.
- Refill: in IRRIGATE, I7=0 for 3 edges → O7=0, O8=1 for 3 cycles. Then I7=1 with I6=1 → O8=0 after 1 edge and O7=1 after 2 edges; O9 stays 0.
- Timeout, REFILL_TIMEOUT=8: hold I7=0 from MONITOR → O8=1 for exactly 8 cycles, then O9=1 and O8=0. O9 stays 1 after I7 returns to 1. H1=0 → O9=0 next edge.
- Priority: in MONITOR, apply I7=0 and I6=1 together → O8=1 and O7 stays 0. In IRRIGATE, drop H1 together with I7=0 → outputs 000 next edge.
